// File: rtl/genius_pkg.sv
// Shared definitions for the genius front end: event codes, default
// timing constants and the input arbitration helpers.
package genius_pkg;

    typedef logic [1:0] ev_code_t;

    localparam ev_code_t EV_BTN0  = 2'd0;
    localparam ev_code_t EV_BTN1  = 2'd1;
    localparam ev_code_t EV_BTN2  = 2'd2;
    localparam ev_code_t EV_START = 2'd3;

    // 20 ms hold time at 50 MHz
    localparam int DEBOUNCE_DEFAULT = 1000000;
    localparam int SYNC_DEFAULT     = 2;

    // Press pulses are packed as {start, btn2, btn1, btn0}.
    // Priority: start > btn0 > btn1 > btn2.
    function automatic ev_code_t pick_winner(input logic [3:0] pulse);
        ev_code_t code;
        if (pulse[3])      code = EV_START;
        else if (pulse[0]) code = EV_BTN0;
        else if (pulse[1]) code = EV_BTN1;
        else               code = EV_BTN2;
        return code;
    endfunction

    // True when more than one press arrived in the same cycle.
    function automatic logic multiple_set(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Press-event handshake between the input conditioner and its consumer.
interface input_conditioner_if;
    import genius_pkg::*;

    logic     ev_valid;
    ev_code_t ev_code;
    logic     ev_ready;

    modport master (output ev_valid, output ev_code, input ev_ready);
    modport slave  (input ev_valid, input ev_code, output ev_ready);

endinterface

// File: rtl/debounce_cell.sv
// One raw asynchronous input: synchronizer, hold-time debouncer,
// registered level output and a one-cycle pulse on each debounced rise.
module debounce_cell
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain; nothing else looks at raw.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; the counter stops at CNT_LAST so it cannot wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (synced == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= synced;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Registered level for the LED echo and a pulse on each 0->1 change.
    always_ff @(posedge clock) begin
        if (reset) begin
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            level <= stable_q;
            rise  <= stable_q & ~level;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounces three buttons and the start key, arbitrates simultaneous
// presses and holds one pending event for the consumer.
module input_conditioner
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          btn,
    input  logic                start,
    input  logic                flag_clr,
    input_conditioner_if.master ev_bus,
    output logic [2:0]          btn_level,
    output logic                overflow
);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] pulse;
    logic       unused_start_level;

    logic       valid_q;
    ev_code_t   code_q;

    ev_code_t   winner;
    logic       any_pulse;
    logic       slot_free;
    logic       overflow_set;

    assign raw = {start, btn};

    for (genvar i = 0; i < 4; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .raw   (raw[i]),
            .level (level[i]),
            .rise  (pulse[i])
        );
    end

    assign btn_level          = level[2:0];
    assign unused_start_level = level[3];

    // Arbitration: the slot is free when empty or being drained this edge.
    // Every loser, and the winner when the slot is busy, is dropped.
    always_comb begin
        winner       = pick_winner(pulse);
        any_pulse    = |pulse;
        slot_free    = !valid_q || ev_bus.ev_ready;
        overflow_set = (any_pulse && !slot_free) || multiple_set(pulse);
    end

    // One-entry event holding register.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            code_q  <= EV_BTN0;
        end else if (any_pulse && slot_free) begin
            valid_q <= 1'b1;
            code_q  <= winner;
        end else if (valid_q && ev_bus.ev_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Sticky drop flag; a new drop beats a clear on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (flag_clr) begin
            overflow <= 1'b0;
        end
    end

    assign ev_bus.ev_valid = valid_q;
    assign ev_bus.ev_code  = code_q;

endmodule
